// File: rtl/mem_bus_fabric.sv
// mem_bus_fabric: picorv32 native-bus address decoder routing one master to NR_SLAVES slaves,
// with unmapped-address and slave-timeout error responses plus an error status block.
module mem_bus_fabric #(
    parameter int                      NR_SLAVES      = 2,
    parameter logic [NR_SLAVES*32-1:0] SLV_BASE       = {32'hF000_0000, 32'h0000_0000},
    parameter logic [NR_SLAVES*32-1:0] SLV_MASK       = {32'hFFFF_F000, 32'hFFFF_E000},
    parameter int                      TIMEOUT_CYCLES = 255,
    parameter logic [31:0]             ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      reset_,
    input  logic                      mem_valid,
    input  logic [31:0]               mem_addr,
    input  logic [31:0]               mem_wdata,
    input  logic [3:0]                mem_wstrb,
    output logic                      mem_ready,
    output logic [31:0]               mem_rdata,
    output logic [NR_SLAVES-1:0]      slv_valid,
    output logic [31:0]               slv_addr,
    output logic [31:0]               slv_wdata,
    output logic [3:0]                slv_wstrb,
    input  logic [NR_SLAVES-1:0]      slv_ready,
    input  logic [NR_SLAVES*32-1:0]   slv_rdata,
    input  logic                      err_clr,
    output logic                      err_pulse,
    output logic                      err_type,
    output logic [31:0]               err_addr,
    output logic [7:0]                err_cnt
);
    localparam int SW = NR_SLAVES > 1 ? $clog2(NR_SLAVES) : 1;
    localparam logic [31:0] TLAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_t;

    state_t        state;
    logic [SW-1:0] sel;
    logic [SW-1:0] hit_idx;
    logic          hit;
    logic [31:0]   timer;
    logic          sel_ready;
    logic          timeout;

    // Scan from the top so the lowest matching slot is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NR_SLAVES - 1; i >= 0; i--)
            if ((mem_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
    end

    assign sel_ready = slv_ready[sel];
    assign timeout   = TIMEOUT_CYCLES != 0 && timer == TLAST;
    assign mem_ready = state == ACCESS ? sel_ready : state == ERR;
    assign mem_rdata = (state == ACCESS && sel_ready) ? slv_rdata[32*sel +: 32] :
                       state == ERR ? ERR_RDATA : 32'd0;

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state     <= IDLE;
            sel       <= '0;
            timer     <= '0;
            slv_valid <= '0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            slv_wstrb <= '0;
            err_pulse <= 1'b0;
            err_type  <= 1'b0;
            err_addr  <= '0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                IDLE: if (mem_valid) begin
                    if (hit) begin
                        state     <= ACCESS;
                        sel       <= hit_idx;
                        slv_valid <= NR_SLAVES'(1) << hit_idx;
                        slv_addr  <= mem_addr;
                        slv_wdata <= mem_wdata;
                        slv_wstrb <= mem_wstrb;
                        timer     <= '0;
                    end else begin
                        state     <= ERR;
                        err_pulse <= 1'b1;
                        err_type  <= 1'b0;
                        err_addr  <= mem_addr;
                        err_cnt   <= err_cnt + {7'd0, err_cnt != 8'hFF};
                    end
                end
                ACCESS: if (sel_ready) begin
                    state     <= IDLE;
                    slv_valid <= '0;
                end else if (timeout) begin
                    state     <= ERR;
                    slv_valid <= '0;
                    err_pulse <= 1'b1;
                    err_type  <= 1'b1;
                    err_addr  <= slv_addr;
                    err_cnt   <= err_cnt + {7'd0, err_cnt != 8'hFF};
                end else begin
                    timer <= timer + 32'd1;
                end
                default: state <= IDLE;
            endcase
            // Clear overrides a same-edge error capture; err_pulse is left alone.
            if (err_clr) begin
                err_cnt  <= '0;
                err_type <= 1'b0;
                err_addr <= '0;
            end
        end
    end
endmodule

// File: doc/mem_bus_fabric.md
MEM_BUS_FABRIC -- requirements
Module: mem_bus_fabric

Interface
REQ-001 SHALL have parameter NR_SLAVES, default 2, number of slave ports (1..16).
REQ-002 SHALL have parameter SLV_BASE, default {32'hF000_0000, 32'h0000_0000}, packed NR_SLAVES*32 base addresses, slot i at bits [32*i+31:32*i].
REQ-003 SHALL have parameter SLV_MASK, default {32'hFFFF_F000, 32'hFFFF_E000}, packed NR_SLAVES*32 decode masks, same packing.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, slave response limit in cycles (0 = timeout disabled).
REQ-005 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF, read data returned on error responses.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset_  input  1  reset, synchronous and active-low.
REQ-008 mem_valid / mem_addr / mem_wdata / mem_wstrb  input  1/32/32/4  master request, picorv32 native bus.
REQ-009 mem_ready / mem_rdata  output  1/32  master response.
REQ-010 slv_valid  output  NR_SLAVES  one-hot per-slave request.
REQ-011 slv_addr / slv_wdata / slv_wstrb  output  32/32/4  shared, registered copies of the accepted request.
REQ-012 slv_ready / slv_rdata  input  NR_SLAVES / NR_SLAVES*32  per-slave response, slot packing as REQ-002.
REQ-013 err_clr  input  1  clears error status and counter.
REQ-014 err_pulse / err_type / err_addr / err_cnt  output  1/1/32/8  error event, type (0 unmapped, 1 timeout), captured address, saturating count.

Function
REQ-015 Slot i hits when (mem_addr & SLV_MASK[i]) == SLV_BASE[i]; on multiple hits the lowest index SHALL win.
REQ-016 FSM states: IDLE, ACCESS, ERR.
REQ-017 IDLE: mem_valid high with hit -> ACCESS, registering slot index, mem_addr, mem_wdata, mem_wstrb; no hit -> ERR, registering mem_addr.
REQ-018 ACCESS: slv_valid[sel]=1, all other bits 0; mem_ready = slv_ready[sel]; mem_rdata = slv_rdata[sel] (combinational pass-through).
REQ-019 ACCESS with slv_ready[sel]=1 -> IDLE next cycle; slv_ready of non-selected slots SHALL be ignored.
REQ-020 Timer cleared on ACCESS entry, increments each ACCESS cycle without slv_ready[sel]; at TIMEOUT_CYCLES-1 with no ready -> ERR, slv_valid deasserted that edge.
REQ-021 ERR lasts exactly one cycle: mem_ready=1, mem_rdata=ERR_RDATA, slv_valid=0; -> IDLE.
REQ-022 On ERR entry: err_pulse=1 for one cycle, err_type/err_addr updated, err_cnt incremented, saturating at 255.
REQ-023 Latency: request accepted at cycle N -> earliest mem_ready at N+1 (slave ready on first ACCESS cycle, or unmapped); timeout response at N+1+TIMEOUT_CYCLES.
REQ-024 IDLE and every non-response cycle: mem_ready=0, mem_rdata=32'd0.
REQ-025 Master request inputs SHALL be sampled only in IDLE; mem_valid drop during ACCESS SHALL NOT abort the slave access.
REQ-026 mem_valid held high after mem_ready SHALL be treated as a new request in the following IDLE cycle (back-to-back = 2 cycles/transfer minimum).
REQ-027 err_clr SHALL zero err_cnt, err_type, err_addr; simultaneous ERR entry and err_clr: clear wins, err_pulse still asserts.
REQ-028 TIMEOUT_CYCLES=0: ACCESS SHALL wait indefinitely.

Reset
REQ-029 reset_ low at clock edge SHALL force IDLE, timer 0, slv_valid 0, mem_ready 0, mem_rdata 0, slv_addr/wdata/wstrb 0, err_pulse 0, err_type 0, err_addr 0, err_cnt 0.
REQ-030 Reset mid-ACCESS or mid-ERR SHALL abandon the transfer with no mem_ready and no error recorded.

Verification
REQ-031 Read 0x0000_0100, slot0 ready on first ACCESS cycle with rdata 0x1234_5678 -> slv_valid=2'b01 at N+1, mem_ready and mem_rdata=0x1234_5678 at N+1.
REQ-032 Write 0xF000_0004, wstrb 4'b0011, slot1 ready after 3 ACCESS cycles -> slv_valid=2'b10, slv_wstrb=4'b0011 for 3 cycles, mem_ready at N+3.
REQ-033 Access 0x8000_0000 -> mem_ready at N+1, mem_rdata=0xDEAD_BEEF, err_type=0, err_addr=0x8000_0000, err_cnt=1.
REQ-034 Access 0x0000_0200, slot0 never ready -> slv_valid drops and mem_ready with 0xDEAD_BEEF at N+256, err_type=1, err_cnt increments.
REQ-035 256 unmapped accesses then err_clr -> err_cnt saturates at 255, then 0; err_clr coincident with ERR entry -> err_cnt 0, err_pulse 1.
REQ-036 reset_ low during timeout wait -> next cycle IDLE, all outputs zero, no mem_ready, err_cnt unchanged at 0.
